pkt_deframer: RTL and testbench
===============================

PKT_DEFRAMER -- requirements
Module: pkt_deframer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the FIFO word and output data width (minimum 32).
REQ-002 SHALL have parameter MAX_PKT_WORDS, default 256, the largest legal payload length in words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port fifo_empty, input, 1, the empty flag of the upstream FIFO.
REQ-006 SHALL have port fifo_rd_en, output, 1, the read strobe to the upstream FIFO.
REQ-007 SHALL have port fifo_dout, input, DATA_WIDTH, the FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have ports m_valid (output, 1) and m_ready (input, 1), the output stream handshake.
REQ-009 SHALL have port m_data, output, DATA_WIDTH, the payload word.
REQ-010 SHALL have ports m_sop and m_eop, output, 1 each, marking the first and last payload word.
REQ-011 SHALL have port m_flags, output, 16, holding header bits [31:16] of the current packet.
REQ-012 SHALL have port err_len, output, 1, a one-cycle pulse on an illegal header length.
REQ-013 SHALL have ports pkt_cnt and drop_cnt, output, 32 each, the statistics counters (see Configuration).

Function
REQ-014 SHALL treat the first FIFO word of each packet as a header (bits [15:0] = LEN in words, bits [31:16] = flags) and the next LEN words as payload.
REQ-015 SHALL assert fifo_rd_en only when fifo_empty=0 and (words buffered + reads in flight) < 2, using a 2-entry internal buffer.
REQ-016 SHALL sustain one payload word per cycle while m_ready=1 and the FIFO is non-empty.
REQ-017 SHALL run a three-state FSM: HDR, PAYLOAD, DROP.
REQ-018 In HDR, SHALL consume the buffered header word internally and never present it on m_data.
REQ-019 In HDR, if 1 <= LEN <= MAX_PKT_WORDS, SHALL latch LEN and m_flags and go to PAYLOAD.
REQ-020 In HDR, if LEN=0, SHALL pulse err_len and remain in HDR.
REQ-021 In HDR, if LEN > MAX_PKT_WORDS, SHALL pulse err_len and go to DROP.
REQ-022 In PAYLOAD, SHALL hold m_valid high while a word is buffered.
REQ-023 SHALL hold m_data, m_sop and m_eop stable while m_valid=1 and m_ready=0.
REQ-024 A transfer occurs when m_valid and m_ready are both 1 in the same cycle.
REQ-025 SHALL assert m_sop on the first payload word and m_eop on word LEN; when LEN=1, both on the same word.
REQ-026 After the m_eop transfer, SHALL return to HDR, with the next header processable on the following cycle.
REQ-027 In DROP, SHALL discard LEN words with m_valid=0, then return to HDR.
REQ-028 SHALL use a 16-bit remaining-word counter that decrements on each transfer or discard, and SHALL leave FIFO-empty stalls mid-packet with no effect other than m_valid=0.
REQ-029 SHALL keep m_valid=0 outside PAYLOAD.

Reset
REQ-030 While rst_n=0, SHALL immediately force state=HDR, clear the buffer and in-flight tracking, and drive fifo_rd_en=0, m_valid=0, m_sop=0, m_eop=0, m_data=0, m_flags=0, err_len=0, pkt_cnt=0, drop_cnt=0.
REQ-031 A reset mid-packet SHALL abandon the packet; the first FIFO word read after release SHALL be treated as a header.

Configuration
REQ-032 With PKT_DEFRAMER_STATS_EN defined, pkt_cnt SHALL increment on each m_eop transfer and drop_cnt on each err_len pulse, both wrapping at 2^32.
REQ-033 Without PKT_DEFRAMER_STATS_EN, pkt_cnt and drop_cnt SHALL be tied to 0 and no counter flops SHALL be synthesised.

Structure
REQ-034 A shared package pkt_pkg SHALL hold the state enum (HDR, PAYLOAD, DROP), the header field bit positions, and the LEN_W=16 constant.
REQ-035 SHALL contain one sub-module, pkt_skid_buf, implementing the 2-entry buffer with FIFO read-latency tracking.

Verification
REQ-036 Header 0x0001_0003 then 0xA, 0xB, 0xC with m_ready=1 SHALL output 0xA (sop), 0xB, 0xC (eop) on consecutive cycles with m_flags=0x0001.
REQ-037 Header LEN=1 with payload 0x55 SHALL output a single word with m_sop=m_eop=1.
REQ-038 With m_ready toggling 1/0 per cycle over a 4-word packet, SHALL deliver all words in order with no loss and stable data while stalled; fifo_rd_en SHALL never fire when fifo_empty=1.
REQ-039 Header LEN=0, then a LEN=2 packet, SHALL give one err_len pulse and correct delivery of the second packet.
REQ-040 Header LEN=300, with MAX_PKT_WORDS=256, SHALL pulse err_len, discard 300 words with m_valid=0, deliver the following packet, and end with drop_cnt=1 and pkt_cnt=1 (STATS_EN).
REQ-041 rst_n asserted after word 2 of a 5-word packet SHALL zero all outputs asynchronously; a new header after release SHALL be parsed correctly.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared state encoding and header field layout for the packet deframer.
package pkt_pkg;

    typedef enum logic [1:0] {
        HDR,
        PAYLOAD,
        DROP
    } state_t;

    // Header word: [15:0] payload length in words, [31:16] flags
    localparam int LEN_W     = 16;
    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 15;
    localparam int FLAGS_LSB = 16;
    localparam int FLAGS_MSB = 31;
    localparam int FLAGS_W   = FLAGS_MSB - FLAGS_LSB + 1;

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry buffer in front of a FIFO whose read data arrives one cycle after
// the read strobe; a read is only issued when a landing slot is guaranteed.
module pkt_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  in_flight;
    logic [1:0]            count;
    logic                  pop_eff;
    logic [2:0]            occupancy;

    assign valid   = (count != 2'd0);
    assign data    = mem[rd_ptr];
    assign pop_eff = pop && valid;

    // A word leaving this cycle frees its slot, which keeps back-to-back reads flowing.
    assign occupancy  = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop_eff};
    assign fifo_rd_en = rst_n && !fifo_empty && (occupancy < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_flight <= 1'b0;
            count     <= 2'd0;
        end else begin
            in_flight <= fifo_rd_en;
            if (in_flight) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_eff) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, in_flight} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/pkt_deframer.sv
// Packet deframer: consumes a LEN/flags header word and streams LEN payload words.
// Define PKT_DEFRAMER_STATS_EN to build the packet and drop statistics counters.
module pkt_deframer
    import pkt_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [15:0]           m_flags,
    output logic                  err_len,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt
);

    localparam logic [31:0] MAX_LEN = 32'(MAX_PKT_WORDS);

    state_t                  state;
    state_t                  state_nxt;
    logic                    buf_valid;
    logic                    buf_pop;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic [LEN_W-1:0]        rem_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        hdr_len;
    logic [FLAGS_W-1:0]      hdr_flags;
    logic                    hdr_zero;
    logic                    hdr_big;
    logic                    last_word;

    pkt_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .data      (buf_data)
    );

    assign hdr_len   = buf_data[LEN_MSB:LEN_LSB];
    assign hdr_flags = buf_data[FLAGS_MSB:FLAGS_LSB];
    assign hdr_zero  = (hdr_len == '0);
    assign hdr_big   = (32'(hdr_len) > MAX_LEN);
    assign last_word = (rem_q == LEN_W'(1));

    // The buffered header never reaches m_data, so outputs are gated by m_valid.
    assign m_data = m_valid ? buf_data : '0;
    assign m_sop  = m_valid && (rem_q == len_q);
    assign m_eop  = m_valid && last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        buf_pop   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            HDR: begin
                if (buf_valid) begin
                    buf_pop = 1'b1;
                    if (hdr_big) begin
                        state_nxt = DROP;
                    end else if (!hdr_zero) begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                m_valid = buf_valid;
                if (buf_valid && m_ready) begin
                    buf_pop = 1'b1;
                    if (last_word) begin
                        state_nxt = HDR;
                    end
                end
            end
            DROP: begin
                if (buf_valid) begin
                    buf_pop = 1'b1;
                    if (last_word) begin
                        state_nxt = HDR;
                    end
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            len_q   <= '0;
            m_flags <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (state == HDR && buf_valid) begin
                err_len <= hdr_zero || hdr_big;
                if (!hdr_zero) begin
                    rem_q <= hdr_len;
                end
                if (!hdr_zero && !hdr_big) begin
                    len_q   <= hdr_len;
                    m_flags <= hdr_flags;
                end
            end else if (buf_pop) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

`ifdef PKT_DEFRAMER_STATS_EN
    logic xfer;
    assign xfer = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (xfer && m_eop) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (err_len) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_deframer.sv
// Self-checking bench for pkt_deframer: queue-based upstream FIFO and scoreboard,
// table-driven packet vectors, randomized traffic and a mid-packet reset.
module tb_pkt_deframer;

    localparam int DW   = 32;
    localparam int MAXW = 256;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic [15:0]   m_flags;
    logic          err_len;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] flags;
    } exp_t;

    typedef struct {
        logic [15:0] len;
        logic [15:0] flags;
        logic [31:0] base;
        int          ready_mode;
        bit          stall;
        int          exp_words;
        int          exp_err;
    } vec_t;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];
    int          xfer_cycles[$];
    int          checks;
    int          passes;
    int          exp_err;
    int          seen_err;
    int          exp_pkts;
    int          cyc;
    int          ready_mode;
    bit          stall_en;
    bit          hold_valid;
    logic [31:0] hold_data;
    logic        hold_sop;
    logic        hold_eop;
    vec_t        vecs[9];

    pkt_deframer #(
        .DATA_WIDTH   (DW),
        .MAX_PKT_WORDS(MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .m_flags   (m_flags),
        .err_len   (err_len),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int stat_exp(input int v);
`ifdef PKT_DEFRAMER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_m_valid"},    32'(m_valid),    0);
        checkOutput({tag, "_m_sop"},      32'(m_sop),      0);
        checkOutput({tag, "_m_eop"},      32'(m_eop),      0);
        checkOutput({tag, "_m_data"},     m_data,          0);
        checkOutput({tag, "_m_flags"},    32'(m_flags),    0);
        checkOutput({tag, "_err_len"},    32'(err_len),    0);
        checkOutput({tag, "_fifo_rd_en"}, 32'(fifo_rd_en), 0);
        checkOutput({tag, "_pkt_cnt"},    pkt_cnt,         0);
        checkOutput({tag, "_drop_cnt"},   drop_cnt,        0);
    endtask

    // Model of one packet: header into the FIFO, payload into the FIFO and the scoreboard.
    task automatic push_pkt(input logic [15:0] len, input logic [15:0] flags, input logic [31:0] base);
        exp_t e;
        fifo_q.push_back({flags, len});
        if (len == 16'd0) begin
            exp_err++;
        end else if (int'(len) > MAXW) begin
            exp_err++;
            for (int i = 0; i < int'(len); i++) fifo_q.push_back(32'hD000_0000 + 32'(i));
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                e.data  = (base == 32'd0) ? $urandom : base + 32'(i);
                e.sop   = (i == 0);
                e.eop   = (i == int'(len) - 1);
                e.flags = flags;
                fifo_q.push_back(e.data);
                exp_q.push_back(e);
            end
            exp_pkts++;
        end
    endtask

    // One clock cycle: drive at the falling edge, sample, then serve the FIFO read.
    task automatic applyStimulus();
        bit   rd;
        exp_t e;
        @(negedge clk);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        fifo_empty = (fifo_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
        #1;
        rd = fifo_rd_en;
        checkOutput("rd_en_while_empty", 32'(rd & fifo_empty), 0);
        if (hold_valid) begin
            checkOutput("stall_valid", 32'(m_valid), 1);
            checkOutput("stall_data",  m_data,       hold_data);
            checkOutput("stall_sop",   32'(m_sop),   32'(hold_sop));
            checkOutput("stall_eop",   32'(m_eop),   32'(hold_eop));
        end
        if (m_valid && m_ready) begin
            xfer_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", m_data, 32'hFFFF_FFFF ^ m_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("data",  m_data,        e.data);
                checkOutput("sop",   32'(m_sop),    32'(e.sop));
                checkOutput("eop",   32'(m_eop),    32'(e.eop));
                checkOutput("flags", 32'(m_flags),  32'(e.flags));
            end
        end
        if (err_len) seen_err++;
        hold_valid = m_valid && !m_ready;
        hold_data  = m_data;
        hold_sop   = m_sop;
        hold_eop   = m_eop;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        if (n >= budget) checkOutput({tag, "_timeout"}, 32'(exp_q.size() + fifo_q.size()), 0);
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput({tag, "_idle_valid"}, 32'(m_valid), 0);
        checkOutput({tag, "_err_pulses"}, 32'(seen_err), 32'(exp_err));
        checkOutput({tag, "_pkt_cnt"},    pkt_cnt,  32'(stat_exp(exp_pkts)));
        checkOutput({tag, "_drop_cnt"},   drop_cnt, 32'(stat_exp(exp_err)));
    endtask

    initial begin
        int          err_before;
        int          n;
        logic [15:0] len;
        int          r;

        checks = 0; passes = 0; exp_err = 0; seen_err = 0; exp_pkts = 0; cyc = 0;
        ready_mode = 0; stall_en = 1'b0; hold_valid = 1'b0;
        hold_data = '0; hold_sop = 1'b0; hold_eop = 1'b0;

        vecs[0] = '{16'd3,   16'h0001, 32'h0000_000A, 0, 1'b0, 3,   0};
        vecs[1] = '{16'd1,   16'h00F0, 32'h0000_0055, 0, 1'b0, 1,   0};
        vecs[2] = '{16'd4,   16'h1234, 32'h0000_0100, 1, 1'b0, 4,   0};
        vecs[3] = '{16'd0,   16'h0BAD, 32'h0000_0000, 0, 1'b0, 0,   1};
        vecs[4] = '{16'd2,   16'hBEEF, 32'h0000_0200, 0, 1'b0, 2,   0};
        vecs[5] = '{16'd300, 16'h0007, 32'h0000_0300, 0, 1'b0, 0,   1};
        vecs[6] = '{16'd2,   16'h0008, 32'h0000_0400, 0, 1'b0, 2,   0};
        vecs[7] = '{16'd256, 16'h0009, 32'h0000_0000, 2, 1'b1, 256, 0};
        vecs[8] = '{16'd257, 16'h000A, 32'h0000_0000, 0, 1'b0, 0,   1};

        rst_n = 1'b0; fifo_empty = 1'b0; m_ready = 1'b1; fifo_dout = '0;
        repeat (3) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        fifo_empty = 1'b1;
        m_ready    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            ready_mode = vecs[k].ready_mode;
            stall_en   = vecs[k].stall;
            err_before = seen_err;
            xfer_cycles.delete();
            push_pkt(vecs[k].len, vecs[k].flags, vecs[k].base);
            drain($sformatf("vec%0d", k), 4000);
            checkOutput($sformatf("vec%0d_words", k), 32'(xfer_cycles.size()), 32'(vecs[k].exp_words));
            checkOutput($sformatf("vec%0d_err", k), 32'(seen_err - err_before), 32'(vecs[k].exp_err));
            if (vecs[k].ready_mode == 0 && !vecs[k].stall && xfer_cycles.size() > 1) begin
                checkOutput($sformatf("vec%0d_back_to_back", k),
                            32'(xfer_cycles[xfer_cycles.size() - 1] - xfer_cycles[0]),
                            32'(vecs[k].exp_words - 1));
            end
        end

        ready_mode = 2;
        stall_en   = 1'b1;
        for (int p = 0; p < 40; p++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      len = 16'd0;
            else if (r == 1) len = 16'(257 + $urandom_range(0, 8));
            else             len = 16'($urandom_range(1, 12));
            push_pkt(len, 16'($urandom), 32'd0);
        end
        drain("random", 30000);

        ready_mode = 0;
        stall_en   = 1'b0;
        xfer_cycles.delete();
        push_pkt(16'd5, 16'h00AA, 32'h0000_0500);
        n = 0;
        while (xfer_cycles.size() < 2 && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("midrst_words_before", 32'(xfer_cycles.size()), 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        fifo_q.delete();
        exp_q.delete();
        exp_err = 0; seen_err = 0; exp_pkts = 0; hold_valid = 1'b0;
        fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer_cycles.delete();
        push_pkt(16'd2, 16'h0C0D, 32'h0000_0600);
        drain("after_rst", 200);
        checkOutput("after_rst_words", 32'(xfer_cycles.size()), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
